// File: rtl/mips_check_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_check_pkg
// Purpose  : Shared state encoding and failure codes for mips_write_checker.
// Revision : 1.0 - initial release
// ============================================================================
package mips_check_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_DATA    = 2'd1;
  localparam logic [1:0] FC_UNEXP   = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage : mips_check_pkg
`default_nettype wire

// File: rtl/mips_write_checker_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up counter with synchronous clear that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active low
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold once saturated; clear wins over inc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : sat_counter
`default_nettype wire

// File: rtl/mips_write_checker.sv
`default_nettype none
// ============================================================================
// Module   : mips_write_checker
// Purpose  : Watches the data-memory store port and checks the stores against
//            an ordered list of expected address/data pairs, with timeout and
//            a sticky pass/fail result plus captured failure record.
// Revision : 1.0 - initial release
// ============================================================================
module mips_write_checker
  import mips_check_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int NUM_CHECKS     = 4,
  parameter bit STRICT         = 1'b0,
  parameter int TIMEOUT_CYCLES = 400
) (
  input  logic                          clk,
  input  logic                          reset,      // asynchronous, active low
  input  logic                          en,
  input  logic                          clear,
  input  logic                          memwrite,
  input  logic [WIDTH-1:0]              adr,
  input  logic [WIDTH-1:0]              writedata,
  input  logic [NUM_CHECKS*WIDTH-1:0]   exp_adr,
  input  logic [NUM_CHECKS*WIDTH-1:0]   exp_data,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic [1:0]                    fail_code,
  output logic [WIDTH-1:0]              fail_adr,
  output logic [WIDTH-1:0]              fail_data,
  output logic [$clog2(NUM_CHECKS+1)-1:0] match_idx,
  output logic [15:0]                   write_count
);

  // NUM_CHECKS >= 1 keeps this at least one bit wide.
  localparam int MW = $clog2(NUM_CHECKS + 1);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [MW-1:0] c_LAST_IDX = MW'(NUM_CHECKS - 1);
  // Timeout fires on the enabled cycle that would bring the count to TIMEOUT_CYCLES.
  localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [MW-1:0]    r_match_idx;
  logic [MW-1:0]    w_match_idx_nxt;
  logic [1:0]       r_fail_code;
  logic [1:0]       w_fail_code_nxt;
  logic [WIDTH-1:0] r_fail_adr;
  logic [WIDTH-1:0] w_fail_adr_nxt;
  logic [WIDTH-1:0] r_fail_data;
  logic [WIDTH-1:0] w_fail_data_nxt;

  logic [WIDTH-1:0] w_sel_adr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_tick;
  logic             w_qual;
  logic [TW-1:0]    w_tcount;

  assign w_tick = (r_state == ST_RUN) && en;
  assign w_qual = w_tick && memwrite;

  // Pick the expected pair currently being waited for.
  always_comb begin
    w_sel_adr  = '0;
    w_sel_data = '0;
    for (int k = 0; k < NUM_CHECKS; k++) begin
      if (r_match_idx == MW'(k)) begin
        w_sel_adr  = exp_adr[k*WIDTH +: WIDTH];
        w_sel_data = exp_data[k*WIDTH +: WIDTH];
      end
    end
  end

  sat_counter #(.WIDTH(16)) u_write_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (w_qual),
    .count (write_count)
  );

  sat_counter #(.WIDTH(TW)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (w_tick),
    .count (w_tcount)
  );

  // Next-state and failure-record logic; store outcomes are resolved before
  // the timeout so a final match in the timeout cycle still passes.
  always_comb begin
    w_state_nxt     = r_state;
    w_match_idx_nxt = r_match_idx;
    w_fail_code_nxt = r_fail_code;
    w_fail_adr_nxt  = r_fail_adr;
    w_fail_data_nxt = r_fail_data;

    if (clear) begin
      w_state_nxt     = ST_RUN;
      w_match_idx_nxt = '0;
      w_fail_code_nxt = FC_NONE;
      w_fail_adr_nxt  = '0;
      w_fail_data_nxt = '0;
    end else if (r_state == ST_RUN) begin
      if (w_qual && (adr == w_sel_adr)) begin
        if (writedata == w_sel_data) begin
          w_match_idx_nxt = r_match_idx + MW'(1);
          if (r_match_idx == c_LAST_IDX) begin
            w_state_nxt = ST_PASS;
          end
        end else begin
          w_state_nxt     = ST_FAIL;
          w_fail_code_nxt = FC_DATA;
          w_fail_adr_nxt  = adr;
          w_fail_data_nxt = writedata;
        end
      end else if (w_qual && STRICT) begin
        w_state_nxt     = ST_FAIL;
        w_fail_code_nxt = FC_UNEXP;
        w_fail_adr_nxt  = adr;
        w_fail_data_nxt = writedata;
      end

      if ((w_state_nxt == ST_RUN) && w_tick && (w_tcount == c_TO_LAST)) begin
        w_state_nxt     = ST_FAIL;
        w_fail_code_nxt = FC_TIMEOUT;
        w_fail_adr_nxt  = '0;
        w_fail_data_nxt = '0;
      end
    end
  end

  // State and failure-record registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_match_idx <= '0;
      r_fail_code <= FC_NONE;
      r_fail_adr  <= '0;
      r_fail_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_match_idx <= w_match_idx_nxt;
      r_fail_code <= w_fail_code_nxt;
      r_fail_adr  <= w_fail_adr_nxt;
      r_fail_data <= w_fail_data_nxt;
    end
  end

  assign pass      = (r_state == ST_PASS);
  assign fail      = (r_state == ST_FAIL);
  assign done      = pass | fail;
  assign fail_code = r_fail_code;
  assign fail_adr  = r_fail_adr;
  assign fail_data = r_fail_data;
  assign match_idx = r_match_idx;

endmodule : mips_write_checker
`default_nettype wire

// File: doc/mips_write_checker.md
# mips_write_checker

Parametrised, synthesizable self-checker that monitors the data-memory write port of `mips_mem` and compares each store against an ordered list of expected address/data pairs. It generalises the single-store Fibonacci check to N expected stores, with a strict or lenient ordering mode, a cycle timeout and sticky pass/fail status with a captured failure record. It sits beside `mips_mem`, shares its clock and taps `memwrite`, `adr` and `writedata`, so it can be used in both the simulation top and on FPGA.

## Interface
- `WIDTH`, 8: data and address width of the monitored bus.
- `NUM_CHECKS`, 4: number of expected stores, ≥1.
- `STRICT`, 0: 1 = any store to an unexpected address fails; 0 = such stores are ignored.
- `TIMEOUT_CYCLES`, 400: enabled cycles allowed before a timeout failure, ≥1.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `en`  in  1  monitoring enable; while 0, the checker ignores stores and the timeout counter holds.
- `clear`  in  1  synchronous restart: counters zeroed, state returns to RUN.
- `memwrite`  in  1  store strobe from `mips_mem`.
- `adr`  in  WIDTH  store address.
- `writedata`  in  WIDTH  store data.
- `exp_adr`  in  NUM_CHECKS*WIDTH  expected addresses; entry i is at `[i*WIDTH +: WIDTH]`.
- `exp_data`  in  NUM_CHECKS*WIDTH  expected data, same packing.
- `done`  out  1  PASS or FAIL reached.
- `pass`  out  1  all expected stores were seen in order.
- `fail`  out  1  failure detected.
- `fail_code`  out  2  0 none, 1 data mismatch, 2 unexpected write, 3 timeout.
- `fail_adr`, `fail_data`  out  WIDTH each  store captured at failure; 0 on timeout.
- `match_idx`  out  max(1,clog2(NUM_CHECKS+1))  count of expected stores matched so far.
- `write_count`  out  16  stores observed while enabled; saturates at 16'hFFFF.

## Operation
- States: RUN, PASS, FAIL. PASS and FAIL are sticky until `reset` or `clear`.
- A qualifying store is a cycle in RUN with `en`=1 and `memwrite`=1. Each qualifying store increments `write_count`.
- For a qualifying store, with i = `match_idx`:
  - `adr`==exp_adr[i] and `writedata`==exp_data[i]: `match_idx` increments. If i==NUM_CHECKS-1, go to PASS.
  - `adr`==exp_adr[i] and data differs: go to FAIL, code 1.
  - `adr`≠exp_adr[i]: if STRICT=1, go to FAIL, code 2; otherwise ignore the store.
- On entry to FAIL with code 1 or 2, `fail_adr` and `fail_data` latch the offending store.
- Timeout counter increments on each RUN cycle with `en`=1. When it reaches TIMEOUT_CYCLES, go to FAIL with code 3.
- If the final match and the timeout occur in the same cycle, the match wins and the state goes to PASS.
- `clear` has priority over every other event in its cycle. It zeroes `match_idx`, `write_count`, the timeout counter and the fail record, and sets state to RUN.
- `exp_adr` and `exp_data` must be held stable while in RUN. They are not registered.

## Timing
- Reset (async, `reset`=0): state RUN; `done`, `pass`, `fail`, `fail_code`, `fail_adr`, `fail_data`, `match_idx`, `write_count` and the timeout counter are all 0.
- All outputs are registered. A store sampled at rising edge k is reflected on the outputs after edge k, so they are valid at edge k+1. Latency is one cycle.
- `done` = `pass` | `fail`. `pass` and `fail` are never both 1.
- In PASS and FAIL, stores are still sampled but change nothing, including `write_count`.
- Reset asserted mid-run takes effect immediately, with no wait for a clock edge.

## Structure
- Package `mips_check_pkg` holds:
  - the state encoding (RUN, PASS, FAIL);
  - the fail-code constants FC_NONE, FC_DATA, FC_UNEXP, FC_TIMEOUT.
- One sub-module, `sat_counter` (parameter WIDTH; ports: clear, inc, count), is used for both `write_count` and the timeout counter.

## Test plan
- Fibonacci: NUM_CHECKS=1, exp 0xEE/0x0D, program the Fibonacci image, release `reset` at 22 ns. Require `pass`=1 and `fail_code`=0 before 4000 ns.
- Ordered sequence: NUM_CHECKS=3, exp (0x10,0x01),(0x11,0x02),(0x12,0x03), drive those three stores. Require `pass` one cycle after the third store and `match_idx`=3.
- Data mismatch: same expected list, drive (0x10,0x01) then (0x11,0x07). Require `fail_code`=1, `fail_adr`=0x11, `fail_data`=0x07, `match_idx`=1.
- STRICT=1: a stray store (0x20,0x55) before the first expected store gives `fail_code`=2. Repeat with STRICT=0: the stray store is ignored and the sequence still passes.
- Timeout: TIMEOUT_CYCLES=10, no stores, `en` held 1 except low for 3 cycles. Require `fail_code`=3 after exactly 10 enabled cycles. Then pulse `clear` and require every output to return to 0.
- Reset mid-run after one match: assert `reset` between edges. Require all outputs at 0 immediately, with no clock edge needed.
